// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch and data ports; MEM_ARB_RR_EN selects round-robin priority (default: data over fetch).
// Latency: the request goes to memory combinationally in IDLE, and gnt follows mem_gnt in the same cycle; a transaction takes at least 2 cycles.
// Backpressure: a requester holds req until its gnt; one transaction is outstanding at a time; no new grant is issued while a response is awaited.
module mem_port_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                CLK,
    input  logic                RES,
    input  logic                instr_req,
    input  logic [ADDR_W-1:0]   instr_addr,
    output logic                instr_gnt,
    output logic                instr_r_valid,
    output logic [DATA_W-1:0]   instr_rdata,
    input  logic                data_req,
    input  logic                data_write_enable,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    input  logic [DATA_W/8-1:0] data_be,
    output logic                data_gnt,
    output logic                data_r_valid,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_gnt,
    input  logic                mem_r_valid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                timeout_err
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

    state_t           state, state_nxt;
    logic             sel_data_q;    // pending selection while waiting in REQ (1 = data)
    logic             owner_data_q;  // side that owns the outstanding transaction (1 = data)
    logic [CNT_W-1:0] tmo_cnt;
    logic             win_data;      // arbitration winner in IDLE
    logic             sel_data;      // side currently presented to memory
    logic             sel_req;
    logic             mem_req_int;
    logic             mem_fire;
    logic             timeout_hit;
    logic             resp_done;

`ifdef MEM_ARB_RR_EN
    logic rr_pref_data;  // preferred side on conflict (1 = data)

    // Round-robin pointer flips to the side that was not just granted
    always_ff @(posedge CLK) begin
        if (RES)
            rr_pref_data <= 1'b0;
        else if (mem_fire)
            rr_pref_data <= ~sel_data;
    end

    assign win_data = data_req && (!instr_req || rr_pref_data);
`else
    // Fixed priority: a pending load/store always goes ahead of a fetch
    assign win_data = data_req;
`endif

    // Selection is frozen in REQ so a late higher-priority request cannot steal the slot
    always_comb begin
        sel_data    = (state == S_REQ) ? sel_data_q : win_data;
        sel_req     = sel_data ? data_req : instr_req;
        mem_req_int = !RES && (state != S_RESP) && sel_req;
        mem_fire    = mem_req_int && mem_gnt;
        timeout_hit = (TIMEOUT_CYCLES > 0) && (state == S_RESP) && !mem_r_valid &&
                      (tmo_cnt == CNT_W'(TIMEOUT_CYCLES));
        resp_done   = (state == S_RESP) && (mem_r_valid || timeout_hit);
    end

    // State register plus the per-transaction bookkeeping that moves with it
    always_ff @(posedge CLK) begin
        if (RES) begin
            state        <= S_IDLE;
            sel_data_q   <= 1'b0;
            owner_data_q <= 1'b0;
            tmo_cnt      <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && mem_req_int && !mem_gnt)
                sel_data_q <= win_data;
            if (mem_fire)
                owner_data_q <= sel_data;
            if (state == S_RESP && !resp_done)
                tmo_cnt <= tmo_cnt + 1'b1;
            else
                tmo_cnt <= '0;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (mem_req_int) state_nxt = mem_gnt ? S_RESP : S_REQ;
            S_REQ: begin
                if (!sel_req)     state_nxt = S_IDLE;  // winner withdrew its request
                else if (mem_gnt) state_nxt = S_RESP;
            end
            S_RESP: if (resp_done) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs: memory fields follow the selected side; all outputs idle at zero
    always_comb begin
        mem_req       = mem_req_int;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        mem_be        = '0;
        instr_gnt     = mem_fire && !sel_data;
        data_gnt      = mem_fire && sel_data;
        instr_r_valid = 1'b0;
        instr_rdata   = '0;
        data_r_valid  = 1'b0;
        data_rdata    = '0;
        timeout_err   = 1'b0;
        if (mem_req_int) begin
            if (sel_data) begin
                mem_we    = data_write_enable;
                mem_addr  = data_addr;
                mem_wdata = data_wdata;
                mem_be    = data_be;
            end else begin
                mem_addr  = instr_addr;
                mem_be    = '1;
            end
        end
        if (!RES && resp_done) begin
            timeout_err = timeout_hit;
            if (owner_data_q) begin
                data_r_valid = 1'b1;
                data_rdata   = mem_r_valid ? mem_rdata : '0;
            end else begin
                instr_r_valid = 1'b1;
                instr_rdata   = mem_r_valid ? mem_rdata : '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios plus a randomized run checked against a transaction-level model.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// The bench acts as both requesters and as a memory with random grant and response timing.
module tb_mem_port_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 4;

    logic          CLK = 1'b0;
    logic          RES;
    logic          instr_req, data_req, data_write_enable;
    logic [AW-1:0] instr_addr, data_addr, mem_addr;
    logic [DW-1:0] data_wdata, mem_rdata, mem_wdata, instr_rdata, data_rdata;
    logic [3:0]    data_be, mem_be;
    logic          instr_gnt, instr_r_valid, data_gnt, data_r_valid;
    logic          mem_req, mem_we, mem_gnt, mem_r_valid, timeout_err;
    logic [138:0]  all_out;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)) dut (
        .CLK(CLK), .RES(RES),
        .instr_req(instr_req), .instr_addr(instr_addr), .instr_gnt(instr_gnt),
        .instr_r_valid(instr_r_valid), .instr_rdata(instr_rdata),
        .data_req(data_req), .data_write_enable(data_write_enable), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_be(data_be), .data_gnt(data_gnt),
        .data_r_valid(data_r_valid), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_r_valid(mem_r_valid), .mem_rdata(mem_rdata),
        .timeout_err(timeout_err)
    );

    always #5 CLK = ~CLK;

    assign all_out = {mem_req, mem_we, mem_addr, mem_wdata, mem_be, instr_gnt, data_gnt,
                      instr_r_valid, instr_rdata, data_r_valid, data_rdata, timeout_err};

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        instr_req = 0; instr_addr = '0; data_req = 0; data_write_enable = 0;
        data_addr = '0; data_wdata = '0; data_be = '0;
        mem_gnt = 0; mem_r_valid = 0; mem_rdata = '0;
    endtask

    task automatic test_reset();
        next_cycle();
        RES = 1; instr_req = 1; data_req = 1; instr_addr = 32'h40; data_addr = 32'h80;
        mem_gnt = 1; mem_r_valid = 1; mem_rdata = 32'hFFFF_FFFF;
        @(negedge CLK);
        checks++;
        if (all_out !== '0) begin
            errors++; $display("FAIL reset_during: outputs=%h required 0", all_out);
        end
        next_cycle();
        RES = 0; clear_inputs();
        @(negedge CLK);
        checks++;
        if (all_out !== '0) begin
            errors++; $display("FAIL reset_after: outputs=%h required 0", all_out);
        end
    endtask

    task automatic test_fetch_only();
        next_cycle();
        instr_req = 1; instr_addr = 32'h100; mem_gnt = 1;
        @(negedge CLK);
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_be, mem_wdata, instr_gnt, data_gnt} !==
            {1'b1, 1'b0, 32'h100, 4'hF, 32'h0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL fetch_grant: req=%b we=%b addr=%h be=%h gnt=%b/%b required 1 0 100 f 1/0",
                               mem_req, mem_we, mem_addr, mem_be, instr_gnt, data_gnt);
        end
        next_cycle();
        instr_req = 0; mem_gnt = 0;
        @(negedge CLK);
        checks++;
        if ({mem_req, instr_gnt, instr_r_valid} !== 3'b000) begin
            errors++; $display("FAIL fetch_resp_wait: req=%b gnt=%b rv=%b required 000", mem_req, instr_gnt, instr_r_valid);
        end
        next_cycle();
        mem_r_valid = 1; mem_rdata = 32'h0050_0093;
        @(negedge CLK);
        checks++;
        if ({instr_r_valid, instr_rdata, data_r_valid, mem_req} !== {1'b1, 32'h0050_0093, 1'b0, 1'b0}) begin
            errors++; $display("FAIL fetch_data: rv=%b rdata=%h drv=%b required 1 00500093 0", instr_r_valid, instr_rdata, data_r_valid);
        end
        next_cycle();
        clear_inputs();
        @(negedge CLK);
        checks++;
        if (all_out !== '0) begin
            errors++; $display("FAIL fetch_idle: outputs=%h required 0", all_out);
        end
    endtask

    task automatic test_conflict();
        logic first_data;
`ifdef MEM_ARB_RR_EN
        first_data = 1'b0;
`else
        first_data = 1'b1;
`endif
        next_cycle();
        RES = 1;
        next_cycle();
        RES = 0;
        instr_req = 1; instr_addr = 32'h104; data_req = 1; data_addr = 32'h2000; mem_gnt = 1;
        @(negedge CLK);
        checks++;
        if ({data_gnt, instr_gnt, mem_addr} !== {first_data, !first_data, first_data ? 32'h2000 : 32'h104}) begin
            errors++; $display("FAIL conflict_first: dgnt=%b ignt=%b addr=%h required dgnt=%b", data_gnt, instr_gnt, mem_addr, first_data);
        end
        next_cycle();
        if (first_data) data_req = 0; else instr_req = 0;
        mem_r_valid = 1; mem_rdata = 32'h1111_2222;
        @(negedge CLK);
        checks++;
        if ({data_r_valid, instr_r_valid, data_gnt, instr_gnt, mem_req} !== {first_data, !first_data, 3'b000}) begin
            errors++; $display("FAIL conflict_resp1: drv=%b irv=%b gnt=%b%b mreq=%b required drv=%b, no grant",
                               data_r_valid, instr_r_valid, data_gnt, instr_gnt, mem_req, first_data);
        end
        next_cycle();
        mem_r_valid = 0;
        @(negedge CLK);
        checks++;
        if ({data_gnt, instr_gnt, mem_addr} !== {!first_data, first_data, first_data ? 32'h104 : 32'h2000}) begin
            errors++; $display("FAIL conflict_second: dgnt=%b ignt=%b addr=%h required dgnt=%b", data_gnt, instr_gnt, mem_addr, !first_data);
        end
        next_cycle();
        clear_inputs();
        mem_r_valid = 1; mem_rdata = 32'h3333_4444;
        @(negedge CLK);
        checks++;
        if ({data_r_valid, instr_r_valid} !== {!first_data, first_data}) begin
            errors++; $display("FAIL conflict_resp2: drv=%b irv=%b required drv=%b", data_r_valid, instr_r_valid, !first_data);
        end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_store();
        next_cycle();
        data_req = 1; data_write_enable = 1; data_addr = 32'h2004; data_wdata = 32'hCAFE_BABE;
        data_be = 4'h3; mem_gnt = 1;
        @(negedge CLK);
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be, data_gnt, instr_gnt} !==
            {1'b1, 1'b1, 32'h2004, 32'hCAFE_BABE, 4'h3, 1'b1, 1'b0}) begin
            errors++; $display("FAIL store_req: we=%b addr=%h wdata=%h be=%h dgnt=%b required 1 2004 cafebabe 3 1",
                               mem_we, mem_addr, mem_wdata, mem_be, data_gnt);
        end
        next_cycle();
        clear_inputs();
        mem_r_valid = 1; mem_rdata = 32'h1234_5678;
        @(negedge CLK);
        checks++;
        if ({data_r_valid, data_rdata, instr_r_valid, instr_rdata} !== {1'b1, 32'h1234_5678, 1'b0, 32'h0}) begin
            errors++; $display("FAIL store_resp: drv=%b drdata=%h irv=%b irdata=%h required 1 12345678 0 0",
                               data_r_valid, data_rdata, instr_r_valid, instr_rdata);
        end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_stalled_grant();
        next_cycle();
        instr_req = 1; instr_addr = 32'h300;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) begin data_req = 1; data_addr = 32'h2000; end
            @(negedge CLK);
            checks++;
            if ({mem_req, mem_addr, instr_gnt, data_gnt} !== {1'b1, 32'h300, 2'b00}) begin
                errors++; $display("FAIL stall_hold_%0d: req=%b addr=%h gnt=%b%b required 1 300 00", c, mem_req, mem_addr, instr_gnt, data_gnt);
            end
            next_cycle();
        end
        mem_gnt = 1;
        @(negedge CLK);
        checks++;
        if ({instr_gnt, data_gnt, mem_addr} !== {2'b10, 32'h300}) begin
            errors++; $display("FAIL stall_grant: ignt=%b dgnt=%b addr=%h required 1 0 300", instr_gnt, data_gnt, mem_addr);
        end
        next_cycle();
        instr_req = 0; mem_r_valid = 1; mem_rdata = 32'hA5A5_0001;
        @(negedge CLK);
        checks++;
        if ({instr_r_valid, instr_rdata, data_gnt} !== {1'b1, 32'hA5A5_0001, 1'b0}) begin
            errors++; $display("FAIL stall_resp: irv=%b irdata=%h dgnt=%b required 1 a5a50001 0", instr_r_valid, instr_rdata, data_gnt);
        end
        next_cycle();
        mem_r_valid = 0;
        @(negedge CLK);
        checks++;
        if ({data_gnt, mem_addr} !== {1'b1, 32'h2000}) begin
            errors++; $display("FAIL stall_data_next: dgnt=%b addr=%h required 1 2000", data_gnt, mem_addr);
        end
        next_cycle();
        clear_inputs();
        mem_r_valid = 1;
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_timeout();
        next_cycle();
        data_req = 1; data_addr = 32'h2008; mem_gnt = 1;
        next_cycle();
        clear_inputs();
        mem_rdata = 32'hDEAD_BEEF;
        for (int c = 1; c <= TMO; c++) begin
            @(negedge CLK);
            checks++;
            if ({timeout_err, data_r_valid} !== 2'b00) begin
                errors++; $display("FAIL timeout_early_%0d: terr=%b drv=%b required 00", c, timeout_err, data_r_valid);
            end
            next_cycle();
        end
        @(negedge CLK);
        checks++;
        if ({timeout_err, data_r_valid, data_rdata, instr_r_valid} !== {2'b11, 32'h0, 1'b0}) begin
            errors++; $display("FAIL timeout_fire: terr=%b drv=%b drdata=%h irv=%b required 1 1 0 0",
                               timeout_err, data_r_valid, data_rdata, instr_r_valid);
        end
        next_cycle();
        mem_r_valid = 1;
        @(negedge CLK);
        checks++;
        if (all_out !== '0) begin
            errors++; $display("FAIL timeout_late_resp: outputs=%h required 0", all_out);
        end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_reset_mid_resp();
        next_cycle();
        instr_req = 1; instr_addr = 32'h500; mem_gnt = 1;
        next_cycle();
        clear_inputs();
        RES = 1;
        next_cycle();
        RES = 0;
        @(negedge CLK);
        checks++;
        if (all_out !== '0) begin
            errors++; $display("FAIL rst_mid_after: outputs=%h required 0", all_out);
        end
        next_cycle();
        mem_r_valid = 1; mem_rdata = 32'h7777_7777;
        @(negedge CLK);
        checks++;
        if (all_out !== '0) begin
            errors++; $display("FAIL rst_mid_stale_resp: outputs=%h required 0", all_out);
        end
        next_cycle();
        clear_inputs();
        data_req = 1; data_addr = 32'h2100; mem_gnt = 1;
        @(negedge CLK);
        checks++;
        if ({data_gnt, mem_addr} !== {1'b1, 32'h2100}) begin
            errors++; $display("FAIL rst_mid_new_req: dgnt=%b addr=%h required 1 2100", data_gnt, mem_addr);
        end
        next_cycle();
        clear_inputs();
        mem_r_valid = 1; mem_rdata = 32'h0BAD_F00D;
        @(negedge CLK);
        checks++;
        if ({data_r_valid, data_rdata} !== {1'b1, 32'h0BAD_F00D}) begin
            errors++; $display("FAIL rst_mid_new_resp: drv=%b drdata=%h required 1 0badf00d", data_r_valid, data_rdata);
        end
        next_cycle();
        clear_inputs();
    endtask

    // Random traffic. Model: a transaction-level view of the shared port (free / waiting on a
    // chosen side / busy for one owner with an age) built from the arbitration rules.
    task automatic test_random();
        int  phase = 0;          // 0 free, 1 chosen but not accepted, 2 awaiting response
        bit  choice = 0, owner = 0, pref = 0;
        int  age = 0;
        bit  i_wait = 0, d_wait = 0, ig_seen = 0, dg_seen = 0, irv_seen = 0, drv_seen = 0;
        logic [73:0] e_mem;
        logic [1:0]  e_gnt;
        logic [66:0] e_rsp;
        bit c, c_req, done;

        next_cycle();
        clear_inputs();
        RES = 1;
        next_cycle();
        RES = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (instr_req && ig_seen) begin instr_req = 0; i_wait = 1; end
            if (data_req && dg_seen) begin data_req = 0; d_wait = 1; end
            if (i_wait && irv_seen) i_wait = 0;
            if (d_wait && drv_seen) d_wait = 0;
            if (!instr_req && !i_wait && ($urandom_range(0, 1) == 1)) begin
                instr_req = 1; instr_addr = $urandom;
            end
            if (!data_req && !d_wait && ($urandom_range(0, 1) == 1)) begin
                data_req = 1; data_addr = $urandom; data_wdata = $urandom;
                data_write_enable = $urandom_range(0, 1); data_be = 4'($urandom_range(0, 15));
            end
            mem_gnt     = ($urandom_range(0, 2) != 0);
            mem_r_valid = ($urandom_range(0, 3) == 0);
            mem_rdata   = $urandom;
            @(negedge CLK);

            e_mem = '0; e_gnt = '0; e_rsp = '0; c = 0; c_req = 0; done = 0;
            if (phase == 0 && (instr_req || data_req)) begin
`ifdef MEM_ARB_RR_EN
                c = data_req && (!instr_req || pref);
`else
                c = data_req;
`endif
                c_req = 1;
            end else if (phase == 1) begin
                c = choice;
                c_req = c ? data_req : instr_req;
            end
            if (phase != 2 && c_req) begin
                e_mem = c ? {1'b1, data_write_enable, data_addr, data_wdata, data_be}
                          : {1'b1, 1'b0, instr_addr, 32'h0, 4'hF};
                if (mem_gnt) e_gnt = c ? 2'b01 : 2'b10;
            end
            if (phase == 2) begin
                if (mem_r_valid) begin
                    done = 1;
                    e_rsp = owner ? {33'h0, 1'b1, mem_rdata, 1'b0} : {1'b1, mem_rdata, 33'h0, 1'b0};
                end else if (age == TMO) begin
                    done = 1;
                    e_rsp = owner ? {33'h0, 1'b1, 32'h0, 1'b1} : {1'b1, 32'h0, 33'h0, 1'b1};
                end
            end

            checks++;
            if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be} !== e_mem) begin
                errors++; $display("FAIL rand_mem cyc %0d: got %h required %h", cyc,
                                   {mem_req, mem_we, mem_addr, mem_wdata, mem_be}, e_mem);
            end
            checks++;
            if ({instr_gnt, data_gnt} !== e_gnt) begin
                errors++; $display("FAIL rand_gnt cyc %0d: got %b required %b", cyc, {instr_gnt, data_gnt}, e_gnt);
            end
            checks++;
            if ({instr_r_valid, instr_rdata, data_r_valid, data_rdata, timeout_err} !== e_rsp) begin
                errors++; $display("FAIL rand_rsp cyc %0d: got %h required %h", cyc,
                                   {instr_r_valid, instr_rdata, data_r_valid, data_rdata, timeout_err}, e_rsp);
            end

            ig_seen = instr_gnt; dg_seen = data_gnt; irv_seen = instr_r_valid; drv_seen = data_r_valid;

            if (phase == 2) begin
                if (done) phase = 0; else age++;
            end else if (c_req) begin
                if (mem_gnt) begin
                    phase = 2; owner = c; age = 0; pref = !c;
                end else begin
                    phase = 1; choice = c;
                end
            end else begin
                phase = 0;
            end
            next_cycle();
        end
        clear_inputs();
    endtask

    initial begin
        RES = 1;
        clear_inputs();
        test_reset();
        test_fetch_only();
        test_conflict();
        test_store();
        test_stalled_grant();
        test_timeout();
        test_reset_mid_resp();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the core's instruction-fetch port and data port.
- Sits between the control unit / datapath request interfaces and the memory.
- Both requester sides keep the existing req/gnt/r_valid handshake unchanged.
- One transaction outstanding at a time; selectable priority; response timeout watchdog.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- TIMEOUT_CYCLES, 255, max cycles from grant to mem_r_valid; 0 disables the watchdog; counter width is clog2(TIMEOUT_CYCLES+1).

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RES  in  1  reset, synchronous, active-high.
- instr_req  in  1  fetch request; held high until instr_gnt.
- instr_addr  in  ADDR_W  fetch address.
- instr_gnt  out  1  fetch grant.
- instr_r_valid  out  1  fetch data valid (1-cycle pulse).
- instr_rdata  out  DATA_W  fetch data.
- data_req  in  1  load/store request; held high until data_gnt.
- data_write_enable  in  1  1 = write, 0 = read.
- data_addr  in  ADDR_W  data address.
- data_wdata  in  DATA_W  store data.
- data_be  in  DATA_W/8  byte enables.
- data_gnt  out  1  data grant.
- data_r_valid  out  1  data response (reads and writes).
- data_rdata  out  DATA_W  load data.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_be  out  DATA_W/8  memory byte enables.
- mem_gnt  in  1  memory accepted request this cycle.
- mem_r_valid  in  1  memory response; asserted once per granted transaction, reads and writes.
- mem_rdata  in  DATA_W  memory read data.
- timeout_err  out  1  1-cycle pulse when the watchdog fires.

Behaviour:
- Reset (RES high at a clock edge): state=IDLE, owner=none, pending selection cleared, timeout counter=0, rr pointer=instr.
  - All outputs 0 during and after reset until new requests arrive; also applies mid-transaction.
  - A response arriving after reset is ignored.
- FSM states: IDLE, REQ, RESP.
- IDLE, no req: mem_req=0, stay.
- IDLE, any req:
  - Choose winner per the priority rule.
  - Drive mem_* combinationally from the winner the same cycle; mem_req=1.
  - If mem_gnt the same cycle: assert winner's gnt (combinational), latch owner, go RESP.
  - Otherwise latch winner as pending selection, go REQ.
- REQ:
  - Selection is frozen to the pending winner; no re-arbitration even if a higher-priority req appears.
  - mem_req=1 with the winner's fields.
  - On mem_gnt: winner gnt=1, owner=winner, go RESP.
  - If the winner's req drops (protocol violation): deassert mem_req, return to IDLE.
- RESP:
  - mem_req=0; both gnt=0; timeout counter increments each cycle.
  - On mem_r_valid: owner's r_valid=1 for that cycle; owner's rdata=mem_rdata; go IDLE; counter cleared.
  - No new grant in the response cycle. Minimum 2 cycles per transaction (grant in IDLE, response next cycle).
- Read data: non-owner rdata is driven 0; instr_rdata/data_rdata are 0 when their r_valid is low.
- Instruction requests: mem_we=0, mem_be=all ones, mem_wdata=0.
- Timeout: if TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES in RESP:
  - Pulse timeout_err.
  - Pulse owner r_valid with rdata=0.
  - Go IDLE.
  - A late mem_r_valid arriving in IDLE/REQ is dropped.
- mem_r_valid in IDLE or REQ (spurious): ignored, no output effect.
- Simultaneous instr_req and data_req in IDLE: resolved by the priority rule; the loser keeps req high and is served next.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin. The 1-bit rr pointer names the preferred requester; after each grant it points to the other requester. On conflict the preferred side wins. Single requesters always win.
- Undefined: fixed priority, data over instruction (a pending load/store must complete before the next fetch); rr pointer logic absent.

Test Plan:
- Fetch only: instr_req=1, addr 0x100; mem_gnt in same cycle; mem_r_valid 2 cycles later with 0x00500093 -> instr_gnt pulse cycle 0; instr_r_valid=1 and instr_rdata=0x00500093 on cycle 2; mem_req low in RESP.
- Conflict: instr_req and data_req (read 0x2000) both high in IDLE, mem_gnt=1 immediately.
  - Without MEM_ARB_RR_EN: data granted first, instr granted in the first IDLE after the data response.
  - With MEM_ARB_RR_EN from reset: instr first, then data.
- Store: data_write_enable=1, addr 0x2004, wdata 0xCAFEBABE, be 0x3 -> mem_we=1, mem_be=0x3, mem_wdata=0xCAFEBABE; data_r_valid pulses when mem_r_valid; instr_r_valid stays 0.
- Stalled grant: instr_req alone, mem_gnt low 3 cycles; data_req rises in cycle 1 -> mem_addr stays instr_addr through REQ; instr granted first.
- Timeout: TIMEOUT_CYCLES=4, grant a read, never assert mem_r_valid -> timeout_err and data_r_valid pulse together with rdata=0 after 4 RESP cycles; a late mem_r_valid has no effect.
- Reset mid-RESP: RES=1 for 1 cycle while awaiting response -> all outputs 0 next cycle; the following mem_r_valid is ignored; the next request is served normally.
